itch50_msg_encoder: RTL
=======================

Name: itch50_msg_encoder

Overview:
- Serializes one parsed order record into a NASDAQ ITCH 5.0 byte stream with a 2-byte big-endian length prefix.
- The output frame is the same format the itch50 parser consumes byte-by-byte.
- Used as the loopback/stimulus source for the parser, and as the market-data replay generator on the Nexys board.
- Record handshake on the input side; byte stream with backpressure on the output side.

Parameters:
- STOCK_LOCATE, 16'h0000, constant emitted in the stock-locate field (bytes 3-4).
- MPID, 32'h4C45484D ("LEHM"), attribution field for 'F' messages (used only with the optional feature).

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- order_type_i  in  4  record type: 4'h1 = Add ('A'), 4'h8 = Delete ('D'), 4'h2 = Add-with-MPID ('F', optional feature only)
- order_ref_num_i  in  32  order reference, low 32 bits
- buy_sell_i  in  1  0 = buy, 1 = sell
- num_shares_i  in  32  share count
- stock_id_i  in  32  first 4 ASCII characters of the symbol
- price_i  in  32  price, 4 implied decimals
- valid_i  in  1  record valid
- ready_o  out  1  encoder can accept a record
- data_o  out  8  stream byte
- valid_o  out  1  data_o valid
- ready_i  in  1  downstream accepts the byte
- last_o  out  1  final byte of the frame, qualified by valid_o
- err_o  out  1  one-cycle pulse when an unsupported order_type_i is accepted

Behaviour:
- Reset values: ready_o=0 while reset_n=0, then 1 from the first clock edge after release. data_o=0, valid_o=0, last_o=0, err_o=0. Timestamp counter = 0. Tracking counter = 0.
- Timestamp: 48-bit free-running counter, increments every clk, wraps 2^48-1 -> 0.
- Record acceptance: a record is accepted when valid_i && ready_o. At that edge all inputs are registered and the timestamp is latched.
- State machine, IDLE -> SEND -> IDLE:
  - IDLE: ready_o=1, valid_o=0.
  - SEND: ready_o=0.
- Frame start: on an accepted valid type, the first byte (length MSB) appears with valid_o=1 in the next cycle (latency 1).
- Byte advance: a byte transfers when valid_o && ready_i. The byte index increments on transfer. data_o, valid_o and last_o hold stable while ready_i=0.
- Frame end: on transfer of the last_o byte, return to IDLE. ready_o is 1 in the following cycle, so there is one idle cycle between frames.
- Unsupported type (including 4'h2 without the feature, and 4'h0): the record is accepted and dropped. err_o=1 for one cycle, the FSM stays in IDLE, no bytes are emitted, and the tracking counter is unchanged.
- Tracking counter: 16-bit, increments by 1 on transfer of each frame's last byte, wraps 16'hFFFF -> 0. Emitted value = counter at frame start.
- All multi-byte fields are big-endian.
- 'A' frame, 38 bytes:
  - [0-1] 00 24
  - [2] 41
  - [3-4] STOCK_LOCATE
  - [5-6] tracking
  - [7-12] timestamp
  - [13-16] 00
  - [17-20] order_ref_num
  - [21] 42 ('B') if buy_sell=0, else 53 ('S')
  - [22-25] num_shares
  - [26-29] stock_id
  - [30-33] 20 (ASCII space pad)
  - [34-37] price
- 'D' frame, 21 bytes:
  - [0-1] 00 13
  - [2] 44
  - [3-16] as for 'A'
  - [17-20] order_ref_num
- Reset mid-frame: the frame is aborted immediately. Outputs go to reset values and no partial frame resumes after release.
- valid_i while busy: ignored, not accepted. The source must hold the record until ready_o=1.

Optional Feature:
- Macro: ITCH_ENC_MPID_EN.
- Defined: order_type_i 4'h2 produces an 'F' frame of 42 bytes:
  - [0-1] 00 28
  - [2] 46
  - [3-37] as for 'A'
  - [38-41] MPID
- Not defined: 4'h2 is an unsupported type (err_o pulse, no frame). Parameter MPID is unused.

Test Plan:
- Add record (type 1, ref 9005, sell, shares 600, stock 41524758, price 00105DD8), ready_i=1 -> 38 bytes: 00 24 41, bytes[17-20] 00 00 23 2D, [21]=53, [22-25] 00 00 02 58, [26-33] 41 52 47 58 20 20 20 20, [34-37] 00 10 5D D8; last_o only on byte 37.
- Delete record (type 8, ref 936) -> 21 bytes: 00 13 44 ... 00 00 03 A8; last_o on byte 20; the next frame's tracking field is 1 greater than this frame's.
- Backpressure: ready_i toggled randomly during an Add frame -> byte sequence identical to the ready_i=1 case; outputs stable whenever ready_i=0; ready_o=0 for the whole frame.
- Type 0 record -> err_o high for exactly 1 cycle, valid_o stays 0, ready_o stays 1, tracking unchanged.
- reset_n asserted at byte 10 of an Add frame -> valid_o=0 asynchronously; after release, a new Delete emits a clean 21-byte frame with tracking=0.
- Loopback: encoder output into the parser for the Add, Delete and (with ITCH_ENC_MPID_EN) 'F' with stock 5A565A5A/price 00015F90 records -> parser outputs equal the encoder inputs; 'F' bytes [38-41] = 4C 45 48 4D.

Source files
------------

// File: rtl/itch50_msg_encoder.sv
// Serializes one order record into a length-prefixed ITCH 5.0 'A' or 'D' frame.
// Define ITCH_ENC_MPID_EN to also encode type 4'h2 as an 'F' (add with MPID) frame.
module itch50_msg_encoder #(
    parameter logic [15:0] STOCK_LOCATE = 16'h0000,
    parameter logic [31:0] MPID         = 32'h4C45484D
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [3:0]  order_type_i,
    input  logic [31:0] order_ref_num_i,
    input  logic        buy_sell_i,
    input  logic [31:0] num_shares_i,
    input  logic [31:0] stock_id_i,
    input  logic [31:0] price_i,
    input  logic        valid_i,
    output logic        ready_o,
    output logic [7:0]  data_o,
    output logic        valid_o,
    input  logic        ready_i,
    output logic        last_o,
    output logic        err_o
);

    localparam int unsigned IDX_W = 6;
    localparam int unsigned TS_W  = 48;
    localparam int unsigned TRK_W = 16;

    localparam logic [3:0] TYPE_ADD  = 4'h1;
    localparam logic [3:0] TYPE_DEL  = 4'h8;
    localparam logic [3:0] TYPE_MPID = 4'h2;

    typedef enum logic {IDLE, SEND} state_t;
    typedef enum logic [1:0] {KIND_A, KIND_D, KIND_F} kind_t;

    typedef struct packed {
        logic [31:0]     ref_num;
        logic            sell;
        logic [31:0]     shares;
        logic [31:0]     stock;
        logic [31:0]     price;
        logic [TS_W-1:0] ts;
    } rec_t;

    state_t             state, state_d;
    kind_t              kind_q, kind_d, in_kind;
    rec_t               rec_q, rec_d;
    logic [TS_W-1:0]    ts_cnt;
    logic [TRK_W-1:0]   trk, trk_d;
    logic [IDX_W-1:0]   idx, idx_d, nidx, last_idx;
    logic [7:0]         data_d, nbyte, type_char, len_byte;
    logic               valid_d, last_d, ready_d, err_d;
    logic               in_ok, accept, xfer;

    // Record type decode
    always_comb begin
        in_ok   = 1'b1;
        in_kind = KIND_A;
        case (order_type_i)
            TYPE_ADD: in_kind = KIND_A;
            TYPE_DEL: in_kind = KIND_D;
`ifdef ITCH_ENC_MPID_EN
            TYPE_MPID: in_kind = KIND_F;
`else
            TYPE_MPID: in_ok = 1'b0;
`endif
            default: in_ok = 1'b0;
        endcase
    end

    always_comb begin
        type_char = 8'h41;
        len_byte  = 8'h24;
        last_idx  = IDX_W'(37);
        case (kind_q)
            KIND_D: begin
                type_char = 8'h44;
                len_byte  = 8'h13;
                last_idx  = IDX_W'(20);
            end
            KIND_F: begin
                type_char = 8'h46;
                len_byte  = 8'h28;
                last_idx  = IDX_W'(41);
            end
            default: ;
        endcase
    end

    assign nidx = idx + IDX_W'(1);

    // Byte at the next index; 'D' frames simply end at index 20
    always_comb begin
        nbyte = 8'h00;
        case (nidx)
            6'd1:  nbyte = len_byte;
            6'd2:  nbyte = type_char;
            6'd3:  nbyte = STOCK_LOCATE[15:8];
            6'd4:  nbyte = STOCK_LOCATE[7:0];
            6'd5:  nbyte = trk[15:8];
            6'd6:  nbyte = trk[7:0];
            6'd7:  nbyte = rec_q.ts[47:40];
            6'd8:  nbyte = rec_q.ts[39:32];
            6'd9:  nbyte = rec_q.ts[31:24];
            6'd10: nbyte = rec_q.ts[23:16];
            6'd11: nbyte = rec_q.ts[15:8];
            6'd12: nbyte = rec_q.ts[7:0];
            6'd17: nbyte = rec_q.ref_num[31:24];
            6'd18: nbyte = rec_q.ref_num[23:16];
            6'd19: nbyte = rec_q.ref_num[15:8];
            6'd20: nbyte = rec_q.ref_num[7:0];
            6'd21: nbyte = rec_q.sell ? 8'h53 : 8'h42;
            6'd22: nbyte = rec_q.shares[31:24];
            6'd23: nbyte = rec_q.shares[23:16];
            6'd24: nbyte = rec_q.shares[15:8];
            6'd25: nbyte = rec_q.shares[7:0];
            6'd26: nbyte = rec_q.stock[31:24];
            6'd27: nbyte = rec_q.stock[23:16];
            6'd28: nbyte = rec_q.stock[15:8];
            6'd29: nbyte = rec_q.stock[7:0];
            6'd30, 6'd31, 6'd32, 6'd33: nbyte = 8'h20;
            6'd34: nbyte = rec_q.price[31:24];
            6'd35: nbyte = rec_q.price[23:16];
            6'd36: nbyte = rec_q.price[15:8];
            6'd37: nbyte = rec_q.price[7:0];
            6'd38: nbyte = MPID[31:24];
            6'd39: nbyte = MPID[23:16];
            6'd40: nbyte = MPID[15:8];
            6'd41: nbyte = MPID[7:0];
            default: nbyte = 8'h00;
        endcase
    end

    assign accept = valid_i && ready_o;
    assign xfer   = valid_o && ready_i;

    // Next-state and registered-output logic
    always_comb begin
        state_d = state;
        kind_d  = kind_q;
        rec_d   = rec_q;
        idx_d   = idx;
        trk_d   = trk;
        data_d  = data_o;
        valid_d = valid_o;
        last_d  = last_o;
        ready_d = ready_o;
        err_d   = 1'b0;
        case (state)
            IDLE: begin
                ready_d = 1'b1;
                valid_d = 1'b0;
                last_d  = 1'b0;
                if (accept) begin
                    if (in_ok) begin
                        state_d = SEND;
                        ready_d = 1'b0;
                        kind_d  = in_kind;
                        rec_d   = '{ref_num: order_ref_num_i, sell: buy_sell_i,
                                    shares: num_shares_i, stock: stock_id_i,
                                    price: price_i, ts: ts_cnt};
                        idx_d   = '0;
                        data_d  = 8'h00;
                        valid_d = 1'b1;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            SEND: begin
                ready_d = 1'b0;
                if (xfer) begin
                    if (last_o) begin
                        state_d = IDLE;
                        valid_d = 1'b0;
                        last_d  = 1'b0;
                        data_d  = 8'h00;
                        ready_d = 1'b1;
                        trk_d   = trk + TRK_W'(1);
                    end else begin
                        idx_d  = nidx;
                        data_d = nbyte;
                        last_d = (nidx == last_idx);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            kind_q  <= KIND_A;
            rec_q   <= '0;
            idx     <= '0;
            trk     <= '0;
            ts_cnt  <= '0;
            data_o  <= 8'h00;
            valid_o <= 1'b0;
            last_o  <= 1'b0;
            ready_o <= 1'b0;
            err_o   <= 1'b0;
        end else begin
            state   <= state_d;
            kind_q  <= kind_d;
            rec_q   <= rec_d;
            idx     <= idx_d;
            trk     <= trk_d;
            ts_cnt  <= ts_cnt + TS_W'(1);
            data_o  <= data_d;
            valid_o <= valid_d;
            last_o  <= last_d;
            ready_o <= ready_d;
            err_o   <= err_d;
        end
    end

endmodule
